det_event_logger: RTL and testbench
===================================

Name: det_event_logger

Overview:
- Downstream stage of the serial 11001 Mealy pattern detector; consumes its 1-cycle `out` pulse on input `det`.
- Counts detections and timestamps each one against a free-running cycle counter.
- Buffers timestamps in a small FIFO for a host or sequencer to pop.
- Flags any detection lost because the FIFO was full.

Parameters:
- TS_W, 8, width of the free-running timestamp counter and of FIFO entries
- DEPTH, 4, FIFO entries; power of two, >=2
- CNT_W, 8, width of the saturating detection counter

Ports:
- clk  in  1  rising-edge clock, shared with the detector
- rst  in  1  synchronous reset, active-high
- det  in  1  detection pulse from the detector; sampled every rising edge
- clr  in  1  synchronous soft clear of the log state (not the timestamp counter)
- rd_en  in  1  pop the FIFO head; ignored when rd_valid=0
- rd_data  out  TS_W  timestamp at the FIFO head (show-ahead); 0 when empty
- rd_valid  out  1  FIFO not empty
- full  out  1  FIFO holds DEPTH entries
- level  out  clog2(DEPTH)+1  current entry count
- hit_cnt  out  CNT_W  total detections since reset/clr; saturates at all-ones
- ovf  out  1  sticky: a detection was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at an edge): ts, FIFO pointers, level, hit_cnt and ovf all go to 0.
  - After reset: rd_valid=0, full=0, rd_data=0.
  - rst has priority over every other input.
- Timestamp ts:
  - Increments by 1 every cycle after reset; wraps modulo 2^TS_W.
  - Not affected by clr.
  - The value pushed for a det sampled at edge k is the ts value held during the cycle before edge k.
  - Example: with det=1 in the first cycle after reset release, the pushed value is 0.
- Push:
  - Occurs at an edge where det=1 and clr=0, and either full=0, or full=1 with a pop in the same edge.
  - The pushed entry is visible at the head on the following cycle if the FIFO was empty.
- Drop:
  - Occurs when det=1, full=1 and no pop in the same edge.
  - Entry is discarded; ovf is set to 1 at that edge; FIFO contents are unchanged.
- Pop:
  - Occurs when rd_en=1, rd_valid=1 and clr=0; the head advances at the edge.
  - rd_en with rd_valid=0 has no effect. An empty FIFO with det=1 and rd_en=1 → push only; level becomes 1.
- Simultaneous push and pop (non-empty FIFO): level is unchanged. On a full FIFO this is accepted, and ovf is not set.
- hit_cnt:
  - +1 on every det=1 edge with clr=0, including dropped detections.
  - Holds at 2^CNT_W-1 once reached.
- clr=1 at an edge:
  - Empties the FIFO; hit_cnt=0; ovf=0.
  - A det or rd_en in the same cycle is ignored: det is not counted and not logged.
- Pointers wrap modulo DEPTH.
- Status outputs:
  - level, full and rd_valid are registered-state derived, with no combinational path from det or rd_en.
  - rd_data is driven from the head entry, gated to 0 when empty.
- Latency: det → rd_valid=1 is 1 cycle when the FIFO was empty.

Test Plan (TS_W=8, DEPTH=4, CNT_W=8 unless stated):
- Basic log and pop:
  - Stimulus: release rst, pulse det at ts=5 and ts=9, then rd_en for 2 cycles.
  - Required: rd_data=5 then 9; rd_valid falls after the second pop; hit_cnt=2; ovf=0.
- Overflow:
  - Stimulus: 5 det pulses at ts=1,2,3,4,6 with no reads.
  - Required: full=1, level=4, ovf=1, hit_cnt=5; pops return 1,2,3,4, then rd_valid=0.
- Full with simultaneous det and rd_en:
  - Stimulus: FIFO full with 1,2,3,4; det at ts=7 with rd_en in the same cycle.
  - Required: level stays 4, ovf=0, entries 2,3,4,7.
- Saturation:
  - Stimulus: CNT_W=3, 9 det pulses interleaved with pops.
  - Required: hit_cnt=7 and holding.
- clr priority:
  - Stimulus: FIFO holding 2 entries, ovf=1; assert clr together with det and rd_en.
  - Required: next cycle level=0, rd_valid=0, hit_cnt=0, ovf=0; ts continues uninterrupted.
- Wrap and mid-run reset:
  - Stimulus: det at ts=255 and ts=0 (after wrap); then assert rst with 2 entries queued.
  - Required: entries 255,0 are stored before the reset; after rst all outputs are 0 and ts restarts at 0.

Source files
------------

// File: rtl/det_event_logger.sv
// det_event_logger: counts and timestamps detector pulses into a small show-ahead FIFO with overflow flag
module det_event_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       det,
    input  logic                       clr,
    input  logic                       rd_en,
    output logic [TS_W-1:0]            rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             pop, push, drop;

    assign rd_valid = level_q != '0;
    assign full     = level_q == LW'(DEPTH);
    assign level    = level_q;
    assign hit_cnt  = hit_q;
    assign ovf      = ovf_q;
    assign rd_data  = rd_valid ? mem_q[rp_q] : '0;

    // A full FIFO still accepts a detection when the head is popped on the same edge.
    always_comb begin
        pop     = rd_en & rd_valid & ~clr;
        push    = det & ~clr & (~full | pop);
        drop    = det & ~clr & full & ~pop;
        ts_d    = ts_q + TS_W'(1);
        wp_d    = clr ? '0 : push ? wp_q + AW'(1) : wp_q;
        rp_d    = clr ? '0 : pop ? rp_q + AW'(1) : rp_q;
        level_d = clr ? '0 : level_q + LW'(push) - LW'(pop);
        hit_d   = clr ? '0 : (det && hit_q != '1) ? hit_q + CNT_W'(1) : hit_q;
        ovf_d   = ~clr & (ovf_q | drop);
        mem_d   = mem_q;
        if (push) mem_d[wp_q] = ts_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q    <= '0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            hit_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_det_event_logger.sv
// tb_det_event_logger: directed checks of the event logger, plus a CNT_W=3 copy for saturation
module tb_det_event_logger;
    logic       clk = 1'b0;
    logic       rst, det, clr, rd_en;
    logic [7:0] rd_data, rd_data3;
    logic       rd_valid, full, ovf, rd_valid3, full3, ovf3;
    logic [2:0] level, level3;
    logic [7:0] hit_cnt;
    logic [2:0] hit_cnt3;
    logic [7:0] ts_m;
    logic [7:0] ts_keep;
    int         n_cmp = 0;
    int         n_err = 0;

    det_event_logger dut (
        .clk(clk), .rst(rst), .det(det), .clr(clr), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .level(level),
        .hit_cnt(hit_cnt), .ovf(ovf)
    );

    det_event_logger #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .det(det), .clr(clr), .rd_en(rd_en),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .full(full3), .level(level3),
        .hit_cnt(hit_cnt3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    // ts_m mirrors the timestamp counter: zero after a reset edge, +1 otherwise
    task automatic tick();
        @(posedge clk);
        ts_m = rst ? 8'd0 : ts_m + 8'd1;
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic det_at(input logic [7:0] t);
        while (ts_m != t) tick();
        det = 1'b1;
        tick();
        det = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int exp);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; det = 1'b0; clr = 1'b0; rd_en = 1'b0; ts_m = 8'd0;
        do_reset();
        chk("rst_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_level", level, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_ovf", ovf, 0);

        // basic log and pop
        det_at(8'd5);
        chk("b_valid1", rd_valid, 1);
        chk("b_head5", rd_data, 5);
        chk("b_level1", level, 1);
        det_at(8'd9);
        chk("b_level2", level, 2);
        chk("b_hit2", hit_cnt, 2);
        pop_chk("b_pop5", 5);
        chk("b_pop9", rd_data, 9);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("b_empty", rd_valid, 0);
        chk("b_data0", rd_data, 0);
        chk("b_hit", hit_cnt, 2);
        chk("b_ovf", ovf, 0);

        // overflow
        do_reset();
        det_at(8'd1); det_at(8'd2); det_at(8'd3); det_at(8'd4);
        chk("o_full4", full, 1);
        det_at(8'd6);
        chk("o_full", full, 1);
        chk("o_level", level, 4);
        chk("o_ovf", ovf, 1);
        chk("o_hit", hit_cnt, 5);
        pop_chk("o_pop1", 1);
        pop_chk("o_pop2", 2);
        pop_chk("o_pop3", 3);
        pop_chk("o_pop4", 4);
        chk("o_empty", rd_valid, 0);
        chk("o_ovf_sticky", ovf, 1);

        // full with simultaneous det and rd_en
        do_reset();
        det_at(8'd1); det_at(8'd2); det_at(8'd3); det_at(8'd4);
        while (ts_m != 8'd7) tick();
        det = 1'b1; rd_en = 1'b1;
        tick();
        det = 1'b0; rd_en = 1'b0;
        chk("f_level", level, 4);
        chk("f_full", full, 1);
        chk("f_ovf", ovf, 0);
        pop_chk("f_pop2", 2);
        pop_chk("f_pop3", 3);
        pop_chk("f_pop4", 4);
        pop_chk("f_pop7", 7);
        chk("f_empty", rd_valid, 0);
        ts_keep = ts_m;
        det = 1'b1; rd_en = 1'b1;
        tick();
        det = 1'b0; rd_en = 1'b0;
        chk("e_pushonly_level", level, 1);
        chk("e_pushonly_data", rd_data, ts_keep);

        // saturation on the CNT_W=3 copy
        do_reset();
        for (int i = 0; i < 9; i++) begin
            det = 1'b1;
            tick();
            det = 1'b0;
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk("s_hit3", hit_cnt3, (i + 1 > 7) ? 7 : i + 1);
        end
        chk("s_hit8", hit_cnt, 9);
        det = 1'b1;
        tick();
        det = 1'b0;
        chk("s_hold", hit_cnt3, 7);
        chk("s_ovf", ovf3, 0);

        // clr priority
        do_reset();
        det = 1'b1;
        repeat (5) tick();
        det = 1'b0;
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        chk("c_pre_level", level, 2);
        chk("c_pre_ovf", ovf, 1);
        chk("c_pre_head", rd_data, 2);
        clr = 1'b1; det = 1'b1; rd_en = 1'b1;
        tick();
        clr = 1'b0; det = 1'b0; rd_en = 1'b0;
        chk("c_level", level, 0);
        chk("c_valid", rd_valid, 0);
        chk("c_hit", hit_cnt, 0);
        chk("c_ovf", ovf, 0);
        chk("c_data", rd_data, 0);
        ts_keep = ts_m;
        det = 1'b1;
        tick();
        det = 1'b0;
        chk("c_ts_cont", rd_data, 8);
        chk("c_ts_model", rd_data, ts_keep);

        // wrap and mid-run reset
        det_at(8'd255);
        det_at(8'd0);
        pop_chk("w_head8", 8);
        chk("w_level", level, 2);
        chk("w_head255", rd_data, 255);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("w_rst_level", level, 0);
        chk("w_rst_valid", rd_valid, 0);
        chk("w_rst_data", rd_data, 0);
        chk("w_rst_full", full, 0);
        chk("w_rst_hit", hit_cnt, 0);
        chk("w_rst_ovf", ovf, 0);
        det = 1'b1;
        tick();
        det = 1'b0;
        chk("w_ts_restart", rd_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
